// File: rtl/formacao_inimigos.sv
// One row of N invaders: block march with edge descent, bullet hit resolution
// and sticky game-over flags (row cleared / row invaded).
module formacao_inimigos #(
   parameter int N        = 5,
   parameter int SPACING  = 80,
   parameter int ENEMY_W  = 33,
   parameter int ENEMY_H  = 24,
   parameter int SCREEN_W = 640,
   parameter int MARGIN   = 5,
   parameter int STEP_X   = 4,
   parameter int STEP_Y   = 16,
   parameter int Y_LIMIT  = 400,
   parameter int PER_BASE = 2,
   parameter int PER_STEP = 2
) (
   input  logic                     CLOCK_MV,
   input  logic                     reset,
   input  logic                     reiniciarJogo,
   input  logic                     pausa,
   input  logic [9:0]               xi,
   input  logic [9:0]               yi,
   input  logic [9:0]               bola_x,
   input  logic [9:0]               bola_y,
   input  logic                     bola_valida,
   output logic [10*N-1:0]          pos_x,
   output logic [9:0]               pos_y,
   output logic [N-1:0]             vivo,
   output logic [$clog2(N+1)-1:0]   n_vivos,
   output logic                     acerto,
   output logic [$clog2(N)-1:0]     acerto_idx,
   output logic                     sentido,
   output logic                     vazia,
   output logic                     invadiu
);

   localparam int NW = $clog2(N+1);
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {MARCHA = 2'd0, DESCE = 2'd1, FIM = 2'd2} estado_t;

   estado_t         estado_r;
   logic [9:0]      base_x_r;
   logic [9:0]      y_r;
   logic [N-1:0]    vivo_r;
   logic [NW-1:0]   n_vivos_r;
   logic            sentido_r;
   logic [15:0]     cnt_r;
   logic            acerto_r;
   logic [IW-1:0]   acerto_idx_r;
   logic            vazia_r;
   logic            invadiu_r;
   logic [10*N-1:0] pos_x_r;

   logic [10:0]     x_s [N];
   logic [N-1:0]    hit_s;
   logic            hit_any_s;
   logic [IW-1:0]   hit_idx_s;
   logic            kill_s;
   logic [N-1:0]    vivo_nxt_s;
   logic [10:0]     esq_s;
   logic [10:0]     dir_s;
   logic [15:0]     periodo_s;
   logic            tick_s;
   logic            borda_s;
   logic [9:0]      base_mov_s;
   logic [10:0]     y_desce_s;
   logic            invade_s;

   // Enemy x positions wrap like the stored 10-bit base; only the hitbox extent needs the 11th bit.
   function automatic logic [10*N-1:0] posicoes(input logic [9:0] base);
      logic [10*N-1:0] p;
      p = {(10*N){1'b0}};
      for (int k = 0; k < N; k++) begin
         p[10*k +: 10] = base + 10'(k * SPACING);
      end
      return p;
   endfunction

   // Hit resolution, alive extents, move period and edge/descent decisions.
   always_comb begin
      hit_any_s = 1'b0;
      hit_idx_s = {IW{1'b0}};
      esq_s     = 11'd0;
      dir_s     = 11'd0;
      for (int k = 0; k < N; k++) begin
         x_s[k]   = {1'b0, base_x_r + 10'(k * SPACING)};
         hit_s[k] = vivo_r[k]
                    && (x_s[k] <= {1'b0, bola_x})
                    && ({1'b0, bola_x} < x_s[k] + 11'(ENEMY_W))
                    && ({1'b0, y_r} <= {1'b0, bola_y})
                    && ({1'b0, bola_y} < {1'b0, y_r} + 11'(ENEMY_H));
      end
      for (int k = N-1; k >= 0; k--) begin
         hit_idx_s = hit_s[k] ? IW'(k) : hit_idx_s;
         esq_s     = vivo_r[k] ? x_s[k] : esq_s;
      end
      for (int k = 0; k < N; k++) begin
         dir_s = vivo_r[k] ? x_s[k] : dir_s;
      end
      hit_any_s  = |hit_s;
      kill_s     = hit_any_s && bola_valida && !pausa
                   && ((estado_r == MARCHA) || (estado_r == DESCE));
      vivo_nxt_s = vivo_r & ~({{(N-1){1'b0}}, kill_s} << hit_idx_s);
      periodo_s  = 16'(PER_BASE) + 16'(n_vivos_r) * 16'(PER_STEP);
      tick_s     = (estado_r == MARCHA) && !pausa && (cnt_r >= periodo_s - 16'd1);
      borda_s    = sentido_r ? (dir_s + 11'(ENEMY_W + STEP_X) > 11'(SCREEN_W - MARGIN))
                             : (esq_s < 11'(MARGIN + STEP_X));
      base_mov_s = sentido_r ? base_x_r + 10'(STEP_X) : base_x_r - 10'(STEP_X);
      y_desce_s  = {1'b0, y_r} + 11'(STEP_Y);
      invade_s   = (y_desce_s + 11'(ENEMY_H)) >= 11'(Y_LIMIT);
   end

   // Row FSM: kills, march ticks, descents and terminal state.
   always_ff @(posedge CLOCK_MV) begin
      if (reset || reiniciarJogo) begin
         estado_r     <= MARCHA;
         base_x_r     <= xi;
         pos_x_r      <= posicoes(xi);
         y_r          <= yi;
         vivo_r       <= {N{1'b1}};
         n_vivos_r    <= NW'(N);
         sentido_r    <= 1'b1;
         cnt_r        <= 16'd0;
         acerto_r     <= 1'b0;
         acerto_idx_r <= {IW{1'b0}};
         vazia_r      <= 1'b0;
         invadiu_r    <= 1'b0;
      end else begin
         acerto_r <= 1'b0;
         if (kill_s) begin
            vivo_r       <= vivo_nxt_s;
            n_vivos_r    <= n_vivos_r - NW'(1);
            acerto_r     <= 1'b1;
            acerto_idx_r <= hit_idx_s;
         end
         case (estado_r)
            MARCHA: begin
               if (kill_s && (vivo_nxt_s == {N{1'b0}})) begin
                  estado_r <= FIM;
                  vazia_r  <= 1'b1;
               end else if (tick_s) begin
                  cnt_r <= 16'd0;
                  if (borda_s) begin
                     estado_r <= DESCE;
                  end else begin
                     base_x_r <= base_mov_s;
                     pos_x_r  <= posicoes(base_mov_s);
                  end
               end else if (!pausa) begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            DESCE: begin
               if (kill_s && (vivo_nxt_s == {N{1'b0}})) begin
                  estado_r <= FIM;
                  vazia_r  <= 1'b1;
               end else if (!pausa) begin
                  y_r       <= y_desce_s[9:0];
                  sentido_r <= ~sentido_r;
                  cnt_r     <= 16'd0;
                  if (invade_s) begin
                     estado_r  <= FIM;
                     invadiu_r <= 1'b1;
                  end else begin
                     estado_r <= MARCHA;
                  end
               end
            end
            FIM: begin
               estado_r <= FIM;
            end
            default: begin
               estado_r <= FIM;
            end
         endcase
      end
   end

   assign pos_x      = pos_x_r;
   assign pos_y      = y_r;
   assign vivo       = vivo_r;
   assign n_vivos    = n_vivos_r;
   assign acerto     = acerto_r;
   assign acerto_idx = acerto_idx_r;
   assign sentido    = sentido_r;
   assign vazia      = vazia_r;
   assign invadiu    = invadiu_r;

endmodule

// File: tb/tb_formacao_inimigos.sv
// Bench for formacao_inimigos: directed scenarios plus a randomized run against
// an integer-arithmetic model of the row's rules.
module tb_formacao_inimigos;

   localparam int N  = 5;
   localparam int SP = 80;
   localparam int W  = 33;
   localparam int H  = 24;
   localparam int SW = 640;
   localparam int MG = 5;
   localparam int SX = 4;
   localparam int SY = 16;
   localparam int YL = 400;
   localparam int PB = 2;
   localparam int PS = 2;

   logic CLOCK_MV = 1'b0;
   always #5 CLOCK_MV = ~CLOCK_MV;

   logic       reset = 1'b1, reiniciarJogo = 1'b0, pausa = 1'b0, bola_valida = 1'b0;
   logic [9:0] xi = 10'd40, yi = 10'd40, bola_x = 10'd0, bola_y = 10'd0;

   logic [10*N-1:0] pos_x;
   logic [9:0]      pos_y;
   logic [N-1:0]    vivo;
   logic [2:0]      n_vivos;
   logic            acerto;
   logic [2:0]      acerto_idx;
   logic            sentido, vazia, invadiu;

   logic [10*N-1:0] pos_x2;
   logic [9:0]      pos_y2;
   logic [N-1:0]    vivo2;
   logic [2:0]      n_vivos2;
   logic            acerto2;
   logic [2:0]      acerto_idx2;
   logic            sentido2, vazia2, invadiu2;

   formacao_inimigos dut (
      .CLOCK_MV(CLOCK_MV), .reset(reset), .reiniciarJogo(reiniciarJogo), .pausa(pausa),
      .xi(xi), .yi(yi), .bola_x(bola_x), .bola_y(bola_y), .bola_valida(bola_valida),
      .pos_x(pos_x), .pos_y(pos_y), .vivo(vivo), .n_vivos(n_vivos), .acerto(acerto),
      .acerto_idx(acerto_idx), .sentido(sentido), .vazia(vazia), .invadiu(invadiu)
   );

   formacao_inimigos #(.SPACING(20)) dut2 (
      .CLOCK_MV(CLOCK_MV), .reset(reset), .reiniciarJogo(reiniciarJogo), .pausa(pausa),
      .xi(xi), .yi(yi), .bola_x(bola_x), .bola_y(bola_y), .bola_valida(bola_valida),
      .pos_x(pos_x2), .pos_y(pos_y2), .vivo(vivo2), .n_vivos(n_vivos2), .acerto(acerto2),
      .acerto_idx(acerto_idx2), .sentido(sentido2), .vazia(vazia2), .invadiu(invadiu2)
   );

   int errors = 0;
   int checks = 0;

   // reference model of the default-parameter instance
   int m_base, m_y, m_dir, m_cnt, m_ph, m_hit, m_idx, m_vazia, m_inv;
   int m_alive [N];

   function automatic int mx(input int k);
      return (m_base + k * SP) % 1024;
   endfunction

   task automatic model_step();
      int na, hk, per, lft, rgt;
      int old_alive [N];
      if (reset || reiniciarJogo) begin
         m_base = int'(xi); m_y = int'(yi); m_dir = 1; m_cnt = 0; m_ph = 0;
         m_hit = 0; m_vazia = 0; m_inv = 0;
         for (int k = 0; k < N; k++) m_alive[k] = 1;
      end else begin
         m_hit = 0;
         na = 0;
         for (int k = 0; k < N; k++) begin
            old_alive[k] = m_alive[k];
            na += m_alive[k];
         end
         hk = -1;
         if (m_ph != 2 && !pausa && bola_valida) begin
            for (int k = N-1; k >= 0; k--) begin
               if (m_alive[k] == 1 && mx(k) <= int'(bola_x) && int'(bola_x) < mx(k) + W
                   && m_y <= int'(bola_y) && int'(bola_y) < m_y + H)
                  hk = k;
            end
         end
         if (hk >= 0) begin
            m_alive[hk] = 0; m_hit = 1; m_idx = hk;
         end
         if (hk >= 0 && na == 1) begin
            m_ph = 2; m_vazia = 1;
         end else if (m_ph == 0 && !pausa) begin
            per = PB + na * PS;
            if (m_cnt >= per - 1) begin
               m_cnt = 0;
               lft = 4096; rgt = -1;
               for (int k = 0; k < N; k++) begin
                  if (old_alive[k] == 1) begin
                     if (mx(k) < lft) lft = mx(k);
                     if (mx(k) > rgt) rgt = mx(k);
                  end
               end
               if ((m_dir == 1) ? (rgt + W + SX > SW - MG) : (lft < MG + SX))
                  m_ph = 1;
               else
                  m_base = (m_base + ((m_dir == 1) ? SX : -SX) + 1024) % 1024;
            end else begin
               m_cnt++;
            end
         end else if (m_ph == 1 && !pausa) begin
            m_y += SY;
            m_dir = 1 - m_dir;
            m_cnt = 0;
            if (m_y + H >= YL) begin
               m_ph = 2; m_inv = 1;
            end else begin
               m_ph = 0;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge CLOCK_MV);
      model_step();
      #1;
   endtask

   task automatic do_reset(input int x0, input int y0);
      reset = 1'b1; xi = 10'(x0); yi = 10'(y0);
      bola_valida = 1'b0; pausa = 1'b0; reiniciarJogo = 1'b0;
      cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(40, 40);
      checks++;
      if ({vivo, n_vivos, pos_x[49:40], pos_x[9:0], pos_y, sentido, acerto, vazia, invadiu}
          !== {5'b11111, 3'd5, 10'd360, 10'd40, 10'd40, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset: got vivo=%b n=%0d x4=%0d x0=%0d y=%0d s=%b a=%b vz=%b inv=%b, want 11111 5 360 40 40 1 0 0 0",
                  vivo, n_vivos, pos_x[49:40], pos_x[9:0], pos_y, sentido, acerto, vazia, invadiu);
      end
   endtask

   task automatic test_march();
      int i;
      do_reset(40, 40);
      for (i = 1; i <= 11; i++) cycle();
      checks++;
      if (pos_x[9:0] !== 10'd40) begin
         errors++; $display("FAIL march_pre: base got %0d want 40", pos_x[9:0]);
      end
      cycle();
      checks++;
      if (pos_x[9:0] !== 10'd44 || pos_x[49:40] !== 10'd364) begin
         errors++; $display("FAIL march_first: base got %0d x4 %0d want 44 364", pos_x[9:0], pos_x[49:40]);
      end
      i = 12;
      while (pos_y == 10'd40 && i < 1200) begin
         cycle(); i++;
      end
      checks++;
      if (i !== 733 || pos_x[9:0] !== 10'd280 || pos_y !== 10'd56 || sentido !== 1'b0) begin
         errors++;
         $display("FAIL march_descent: cycles=%0d base=%0d y=%0d s=%b want 733 280 56 0", i, pos_x[9:0], pos_y, sentido);
      end
   endtask

   task automatic test_hit();
      do_reset(40, 40);
      bola_x = 10'd45; bola_y = 10'd50; bola_valida = 1'b1;
      cycle();
      bola_valida = 1'b0;
      checks++;
      if (acerto !== 1'b1 || acerto_idx !== 3'd0 || vivo !== 5'b11110 || n_vivos !== 3'd4) begin
         errors++;
         $display("FAIL hit: acerto=%b idx=%0d vivo=%b n=%0d want 1 0 11110 4", acerto, acerto_idx, vivo, n_vivos);
      end
      cycle();
      checks++;
      if (acerto !== 1'b0) begin
         errors++; $display("FAIL hit_pulse: acerto got %b want 0", acerto);
      end
      for (int i = 3; i <= 9; i++) cycle();
      checks++;
      if (pos_x[9:0] !== 10'd40) begin
         errors++; $display("FAIL hit_period_pre: base got %0d want 40", pos_x[9:0]);
      end
      cycle();
      checks++;
      if (pos_x[9:0] !== 10'd44) begin
         errors++; $display("FAIL hit_period: base got %0d want 44 after 10 cycles", pos_x[9:0]);
      end
   endtask

   task automatic test_overlap();
      do_reset(40, 40);
      bola_x = 10'd65; bola_y = 10'd50; bola_valida = 1'b1;
      cycle();
      checks++;
      if (acerto2 !== 1'b1 || acerto_idx2 !== 3'd0 || vivo2 !== 5'b11110) begin
         errors++; $display("FAIL overlap_first: acerto=%b idx=%0d vivo=%b want 1 0 11110", acerto2, acerto_idx2, vivo2);
      end
      cycle();
      bola_valida = 1'b0;
      checks++;
      if (acerto2 !== 1'b1 || acerto_idx2 !== 3'd1 || vivo2 !== 5'b11100) begin
         errors++; $display("FAIL overlap_second: acerto=%b idx=%0d vivo=%b want 1 1 11100", acerto2, acerto_idx2, vivo2);
      end
   endtask

   task automatic test_back_to_back();
      do_reset(40, 40);
      for (int k = 0; k < N; k++) begin
         bola_x = 10'(45 + k * SP); bola_y = 10'd50; bola_valida = 1'b1;
         cycle();
         checks++;
         if (acerto !== 1'b1 || acerto_idx !== 3'(k)) begin
            errors++; $display("FAIL kill_seq: k=%0d acerto=%b idx=%0d want 1 %0d", k, acerto, acerto_idx, k);
         end
      end
      bola_valida = 1'b0;
      checks++;
      if (vazia !== 1'b1 || vivo !== 5'b00000 || n_vivos !== 3'd0) begin
         errors++; $display("FAIL kill_all: vazia=%b vivo=%b n=%0d want 1 00000 0", vazia, vivo, n_vivos);
      end
      for (int i = 0; i < 40; i++) cycle();
      checks++;
      if (pos_x[9:0] !== 10'd40 || acerto !== 1'b0 || vazia !== 1'b1) begin
         errors++; $display("FAIL kill_hold: base=%0d acerto=%b vazia=%b want 40 0 1", pos_x[9:0], acerto, vazia);
      end
   endtask

   task automatic test_pause();
      do_reset(40, 40);
      for (int i = 0; i < 5; i++) cycle();
      pausa = 1'b1;
      bola_x = 10'd45; bola_y = 10'd50; bola_valida = 1'b1;
      for (int i = 0; i < 20; i++) cycle();
      checks++;
      if (acerto !== 1'b0 || vivo !== 5'b11111 || pos_x[9:0] !== 10'd40) begin
         errors++; $display("FAIL pause_freeze: acerto=%b vivo=%b base=%0d want 0 11111 40", acerto, vivo, pos_x[9:0]);
      end
      pausa = 1'b0; bola_valida = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      checks++;
      if (pos_x[9:0] !== 10'd40) begin
         errors++; $display("FAIL pause_resume_pre: base got %0d want 40", pos_x[9:0]);
      end
      cycle();
      checks++;
      if (pos_x[9:0] !== 10'd44) begin
         errors++; $display("FAIL pause_resume: base got %0d want 44", pos_x[9:0]);
      end
   endtask

   task automatic test_invade();
      int i;
      logic [9:0] held;
      do_reset(40, 40);
      i = 0;
      while (invadiu !== 1'b1 && i < 20000) begin
         cycle(); i++;
      end
      checks++;
      if (invadiu !== 1'b1 || pos_y !== 10'd376) begin
         errors++; $display("FAIL invade: invadiu=%b y=%0d after %0d cycles want 1 376", invadiu, pos_y, i);
      end
      held = pos_x[9:0];
      bola_x = pos_x[9:0] + 10'd2; bola_y = 10'd380; bola_valida = 1'b1;
      for (int j = 0; j < 30; j++) cycle();
      bola_valida = 1'b0;
      checks++;
      if (pos_x[9:0] !== held || pos_y !== 10'd376 || vivo !== 5'b11111) begin
         errors++; $display("FAIL invade_hold: base=%0d y=%0d vivo=%b want %0d 376 11111", pos_x[9:0], pos_y, vivo, held);
      end
      reiniciarJogo = 1'b1; xi = 10'd40; yi = 10'd40;
      cycle();
      reiniciarJogo = 1'b0;
      checks++;
      if ({pos_x[9:0], pos_y, vivo, n_vivos, sentido, acerto, vazia, invadiu}
          !== {10'd40, 10'd40, 5'b11111, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL restart: base=%0d y=%0d vivo=%b n=%0d s=%b a=%b vz=%b inv=%b want 40 40 11111 5 1 0 0 0",
                  pos_x[9:0], pos_y, vivo, n_vivos, sentido, acerto, vazia, invadiu);
      end
   endtask

   task automatic test_random();
      logic [10*N-1:0] ex_px;
      logic [N-1:0]    ex_vivo;
      int              cnt_alive, k, bx, by;
      reiniciarJogo = 1'b1; xi = 10'd100; yi = 10'd200;
      cycle();
      reiniciarJogo = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         pausa = ($urandom_range(9) == 0);
         reiniciarJogo = ($urandom_range(399) == 0) || (m_ph == 2 && $urandom_range(19) == 0);
         xi = 10'($urandom_range(278, 9));
         yi = 10'($urandom_range(300));
         if ($urandom_range(2) == 0) begin
            k  = $urandom_range(N-1);
            bx = mx(k) + $urandom_range(W+3) - 2;
            by = m_y + $urandom_range(H+3) - 2;
         end else begin
            bx = $urandom_range(1023);
            by = $urandom_range(1023);
         end
         bola_x = 10'((bx < 0) ? 0 : bx);
         bola_y = 10'((by < 0) ? 0 : by);
         bola_valida = ($urandom_range(9) < 7);
         cycle();
         cnt_alive = 0;
         for (int j = 0; j < N; j++) begin
            ex_px[10*j +: 10] = 10'(mx(j));
            ex_vivo[j] = m_alive[j][0];
            cnt_alive += m_alive[j];
         end
         checks++;
         if ({pos_x, pos_y, vivo, n_vivos, acerto, sentido, vazia, invadiu}
             !== {ex_px, 10'(m_y), ex_vivo, 3'(cnt_alive), m_hit[0], m_dir[0], m_vazia[0], m_inv[0]}) begin
            errors++;
            $display("FAIL random_state: cyc=%0d got px=%h y=%0d v=%b n=%0d a=%b s=%b vz=%b inv=%b want px=%h y=%0d v=%b n=%0d a=%0d s=%0d vz=%0d inv=%0d",
                     n, pos_x, pos_y, vivo, n_vivos, acerto, sentido, vazia, invadiu,
                     ex_px, m_y, ex_vivo, cnt_alive, m_hit, m_dir, m_vazia, m_inv);
         end
         if (m_hit == 1) begin
            checks++;
            if (acerto_idx !== 3'(m_idx)) begin
               errors++; $display("FAIL random_idx: cyc=%0d got %0d want %0d", n, acerto_idx, m_idx);
            end
         end
      end
      reiniciarJogo = 1'b0; pausa = 1'b0; bola_valida = 1'b0;
   endtask

   initial begin
      test_reset();
      test_march();
      test_hit();
      test_overlap();
      test_back_to_back();
      test_pause();
      test_invade();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/formacao_inimigos.md
# formacao_inimigos

Parametrised enemy-row controller for the invaders playfield: N enemies sharing one row, marching horizontally as a block, stepping down and reversing at the screen edges, and speeding up as enemies die. It resolves player-bullet hits against every enemy in the same cycle and flags game-over conditions (row cleared, row reached the player zone). It is self-contained: no per-enemy submodules. One instance drives one row; the top level stacks instances with different `yi`.

## Interface
- `N`, 5: enemies per row; N ≥ 2.
- `SPACING`, 80: x distance between adjacent enemies, in pixels.
- `ENEMY_W`, 33 / `ENEMY_H`, 24: enemy hitbox size, in pixels.
- `SCREEN_W`, 640: playfield width. `MARGIN`, 5: edge margin on both sides.
- `STEP_X`, 4: horizontal step per move. `STEP_Y`, 16: vertical step per descent.
- `Y_LIMIT`, 400: invasion line, in pixels.
- `PER_BASE`, 2 / `PER_STEP`, 2: move period = PER_BASE + n_vivos·PER_STEP cycles.
- `CLOCK_MV` input 1: movement clock; all state updates on its rising edge.
- `reset` input 1: reset, synchronous, active-high; clock CLOCK_MV.
- `reiniciarJogo` input 1: synchronous restart; identical effect to `reset`.
- `pausa` input 1: freezes the period counter, moves and hit detection.
- `xi` input 10: base x of enemy 0, loaded at reset or restart.
- `yi` input 10: row y, loaded at reset or restart.
- `bola_x`, `bola_y` input 10 each: player bullet position.
- `bola_valida` input 1: bullet is in flight.
- `pos_x` output 10·N: enemy k's x is at bits [10k+9:10k]; dead enemies still report their position.
- `pos_y` output 10: shared row y.
- `vivo` output N: alive mask; bit k is enemy k.
- `n_vivos` output $clog2(N+1): population count of `vivo`.
- `acerto` output 1: one-cycle pulse when the bullet kills an enemy.
- `acerto_idx` output $clog2(N): index of the killed enemy; valid while `acerto`=1.
- `sentido` output 1: march direction; 1 = right, 0 = left.
- `vazia` output 1: all enemies dead; sticky.
- `invadiu` output 1: row reached `Y_LIMIT`; sticky.

## Operation
- State: `base_x`, `y`, `vivo`, `sentido`, period counter `cnt`, FSM {MARCHA, DESCE, FIM}.
- Enemy k's x is always `base_x + k·SPACING`; only `base_x` is stored.
- All comparisons use 11-bit arithmetic so that x + W cannot wrap.
- Reset/restart values: `base_x`=xi, `y`=yi, `vivo`=all ones, `n_vivos`=N, `sentido`=1, `cnt`=0, `acerto`=0, `vazia`=0, `invadiu`=0, state MARCHA. Restart has effect in every state, including FIM.
- Hit detection, active in MARCHA and DESCE when `pausa`=0 and `bola_valida`=1:
  - An enemy k is hit if it is alive, `x_k ≤ bola_x < x_k+ENEMY_W` and `y ≤ bola_y < y+ENEMY_H`.
  - Only the lowest-index hit enemy is killed per cycle: its `vivo` bit is cleared, `acerto`=1 and `acerto_idx`=k.
  - The bullet owner clears the bullet on `acerto`.
- Move tick: when `pausa`=0 and state MARCHA, `cnt` increments. When `cnt` ≥ period−1, `cnt`←0 and a move happens.
  - Period uses registered `n_vivos`, so a change takes effect from the next count.
  - On a move, L = leftmost alive x and R = rightmost alive x.
  - If `sentido`=1 and R+ENEMY_W+STEP_X > SCREEN_W−MARGIN → go to DESCE.
  - If `sentido`=0 and L < MARGIN+STEP_X → go to DESCE.
  - Otherwise `base_x` ± STEP_X.
- DESCE, one cycle:
  - `y` += STEP_Y, `sentido` flips.
  - If new y+ENEMY_H ≥ Y_LIMIT → FIM with `invadiu`=1; else → MARCHA.
  - `pausa`=1 holds DESCE.
- Kill that leaves `vivo`=0 → FIM with `vazia`=1 on the same edge the last bit clears. This has priority over a simultaneous move.
- Hit and move on the same cycle: the hit is tested against pre-move positions. The edge test uses the pre-kill `vivo`.
- FIM: no moves and no hits; outputs hold until reset or restart.

## Timing
- All outputs registered. Inputs sampled at edge t are reflected after edge t (latency 1).
- `acerto` is high for exactly one cycle per kill. Back-to-back kills on consecutive cycles are allowed.
- With 5 alive, defaults: a move every 12 cycles; with 1 alive, every 4.
- A descent costs one extra cycle, and `cnt` restarts at 0 on return to MARCHA.

## Test plan
- Reset, xi=40, yi=40, no bullet → `base_x` 40→44 after 12 cycles; `pos_x` of enemy 4 = 360; `vivo`=11111, `n_vivos`=5.
- March right from base 40 → 60 moves to base 280, then DESCE: y=56, `sentido`=0, `base_x` stays 280.
- Bullet (45,50) valid at base 40 → `acerto`=1 for 1 cycle, `acerto_idx`=0, `vivo`=11110, and the next period is 10.
- Bullet in overlapping range of two enemies (SPACING reduced to 20, bullet x=65) → only the lower index is killed.
- Kill all 5 sequentially → `vazia`=1 and FIM on the 5th kill; then no movement.
- Let the row descend 21 times (y=376) → `invadiu`=1, FIM. Then `reiniciarJogo` → all reset values restored next cycle. Also assert `pausa` mid-period: `cnt` and positions freeze and a bullet on an enemy gives no hit.
